// File: rtl/ysyx_25040111_axi_arbiter.sv
// Shares the single io_master AXI4 port between IFU (read) and LSU (read/write), one single-beat transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin IFU/LSU arbitration; default is fixed priority LSU over IFU.
//
// state  | meaning
// IDLE   | nothing forwarded, arbitrate sampled requests
// IFU_RD | IFU AR/R channels wired to io_master
// LSU_RD | LSU AR/R channels wired to io_master
// LSU_WR | LSU AW/W/B channels wired to io_master
module ysyx_25040111_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                ifu_rready,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  input  logic                lsu_bready,
  output logic                io_master_arvalid,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_arready,
  input  logic                io_master_rvalid,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid,
  output logic                io_master_rready,
  output logic                io_master_awvalid,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  input  logic                io_master_awready,
  output logic                io_master_wvalid,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_wready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid,
  output logic                io_master_bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state;
  state_t pick;
  logic   ar_done, aw_done, w_done;
  logic   rd_last, wr_last, lsu_req;
  logic   unused_ids;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_grant_lsu;
`endif

  assign unused_ids = ^{io_master_rid, io_master_bid};
  assign rd_last    = io_master_rvalid & io_master_rready & io_master_rlast;
  assign wr_last    = io_master_bvalid & io_master_bready;
  assign lsu_req    = lsu_arvalid | lsu_awvalid;

  always_comb begin
    pick = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
    if (ifu_arvalid && lsu_req && last_grant_lsu) pick = IFU_RD;
    else if (lsu_req)                             pick = lsu_arvalid ? LSU_RD : LSU_WR;
    else if (ifu_arvalid)                         pick = IFU_RD;
`else
    if (lsu_req)          pick = lsu_arvalid ? LSU_RD : LSU_WR;
    else if (ifu_arvalid) pick = IFU_RD;
`endif
  end

  // done flags stop a held valid from issuing a second beat inside one grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_lsu <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state   <= pick;
          ar_done <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        IFU_RD, LSU_RD: begin
          if (io_master_arvalid && io_master_arready) ar_done <= 1'b1;
          if (rd_last) begin
            state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_lsu <= (state == LSU_RD);
`endif
          end
        end
        LSU_WR: begin
          if (io_master_awvalid && io_master_awready) aw_done <= 1'b1;
          if (io_master_wvalid && io_master_wready)   w_done  <= 1'b1;
          if (wr_last) begin
            state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_lsu <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_master_arid    = 4'd0;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_awid    = 4'd0;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_wlast   = io_master_wvalid;

  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arsize  = 3'b000;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awsize  = 3'b000;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_bready  = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = 2'b00;
    case (state)
      IFU_RD: begin
        io_master_arvalid = ifu_arvalid & ~ar_done;
        io_master_araddr  = ifu_araddr;
        io_master_arsize  = 3'b010;
        ifu_arready       = io_master_arready & ~ar_done;
        ifu_rvalid        = io_master_rvalid;
        ifu_rdata         = io_master_rdata;
        ifu_rresp         = io_master_rresp;
        io_master_rready  = ifu_rready;
      end
      LSU_RD: begin
        io_master_arvalid = lsu_arvalid & ~ar_done;
        io_master_araddr  = lsu_araddr;
        io_master_arsize  = lsu_arsize;
        lsu_arready       = io_master_arready & ~ar_done;
        lsu_rvalid        = io_master_rvalid;
        lsu_rdata         = io_master_rdata;
        lsu_rresp         = io_master_rresp;
        io_master_rready  = lsu_rready;
      end
      LSU_WR: begin
        io_master_awvalid = lsu_awvalid & ~aw_done;
        io_master_awaddr  = lsu_awaddr;
        io_master_awsize  = lsu_awsize;
        lsu_awready       = io_master_awready & ~aw_done;
        io_master_wvalid  = lsu_wvalid & ~w_done;
        io_master_wdata   = lsu_wdata;
        io_master_wstrb   = lsu_wstrb;
        lsu_wready        = io_master_wready & ~w_done;
        lsu_bvalid        = io_master_bvalid;
        lsu_bresp         = io_master_bresp;
        io_master_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// Directed bench for ysyx_25040111_axi_arbiter: a vector table of single transactions plus
// contention and mid-transaction reset sequences. Honors ARB_ROUND_ROBIN_EN for the grant order.
module tb_ysyx_25040111_axi_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0] ifu_rresp;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [2:0] lsu_arsize, lsu_awsize;
  logic [1:0] lsu_rresp, lsu_bresp;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0] lsu_wstrb;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0] m_arid, m_rid, m_awid, m_bid;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_rresp, m_awburst, m_bresp;
  logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0] m_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          kind;      // 0 IFU read, 1 LSU read, 2 LSU write
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          aw_cyc;
    int          w_cyc;
    logic [2:0]  exp_size;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_wbeats;
  } vec_t;

  vec_t vecs[6];

  ysyx_25040111_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr), .io_master_arid(m_arid),
    .io_master_arlen(m_arlen), .io_master_arsize(m_arsize), .io_master_arburst(m_arburst),
    .io_master_arready(m_arready),
    .io_master_rvalid(m_rvalid), .io_master_rdata(m_rdata), .io_master_rresp(m_rresp),
    .io_master_rlast(m_rlast), .io_master_rid(m_rid), .io_master_rready(m_rready),
    .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr), .io_master_awid(m_awid),
    .io_master_awlen(m_awlen), .io_master_awsize(m_awsize), .io_master_awburst(m_awburst),
    .io_master_awready(m_awready),
    .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata), .io_master_wstrb(m_wstrb),
    .io_master_wlast(m_wlast), .io_master_wready(m_wready),
    .io_master_bvalid(m_bvalid), .io_master_bresp(m_bresp), .io_master_bid(m_bid),
    .io_master_bready(m_bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic grant_wait(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (m_arvalid || m_awvalid) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_timeout: got no grant expected grant within 16 cycles");
    end
  endtask

  // Entered just after the negedge on which the grant became visible; exits in the following IDLE cycle.
  task automatic serve_read(input bit is_lsu, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input logic [2:0] exp_size,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
    chk("araddr", m_araddr, addr);
    chk("arsize", m_arsize, exp_size);
    chk("arlen_burst_id", {m_arlen, m_arburst, m_arid}, {8'd0, 2'b01, 4'd0});
    m_arready = 1'b1;
    #1;
    chk("req_arready", is_lsu ? lsu_arready : ifu_arready, 1'b1);
    chk("other_arready", is_lsu ? ifu_arready : lsu_arready, 1'b0);
    @(negedge clk);
    if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = data; m_rresp = resp; m_rlast = 1'b1;
    if (is_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
    #1;
    chk("arvalid_after_hs", m_arvalid, 1'b0);
    chk("req_rvalid", is_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
    chk("req_rdata", is_lsu ? lsu_rdata : ifu_rdata, exp_data);
    chk("req_rresp", is_lsu ? lsu_rresp : ifu_rresp, exp_resp);
    chk("other_rvalid", is_lsu ? ifu_rvalid : lsu_rvalid, 1'b0);
    chk("m_rready", m_rready, 1'b1);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    lsu_rready = 1'b0; ifu_rready = 1'b0;
    #1;
    chk("idle_arvalid", m_arvalid, 1'b0);
    chk("idle_rready", m_rready, 1'b0);
  endtask

  task automatic serve_write(input vec_t v);
    int wbeats = 0;
    int last_c = (v.aw_cyc > v.w_cyc) ? v.aw_cyc : v.w_cyc;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      lsu_awvalid = (c <= v.aw_cyc);
      m_awready   = (c == v.aw_cyc);
      lsu_wvalid  = (c == v.w_cyc);
      m_wready    = (c == v.w_cyc);
      #1;
      chk("awvalid", m_awvalid, c <= v.aw_cyc);
      chk("lsu_awready", lsu_awready, c == v.aw_cyc);
      chk("wvalid", m_wvalid, c == v.w_cyc);
      chk("lsu_wready", lsu_wready, c == v.w_cyc);
      if (c == v.aw_cyc) begin
        chk("awaddr", m_awaddr, v.addr);
        chk("awsize", m_awsize, v.exp_size);
        chk("awlen_burst_id", {m_awlen, m_awburst, m_awid}, {8'd0, 2'b01, 4'd0});
      end
      if (m_wvalid && m_wready) begin
        wbeats++;
        chk("wdata", m_wdata, v.exp_data);
        chk("wstrb", m_wstrb, v.strb);
        chk("wlast", m_wlast, 1'b1);
      end
    end
    @(negedge clk);
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = v.resp; lsu_bready = 1'b1;
    #1;
    chk("wvalid_after_hs", m_wvalid, 1'b0);
    chk("lsu_bvalid", lsu_bvalid, 1'b1);
    chk("lsu_bresp", lsu_bresp, v.exp_resp);
    chk("m_bready", m_bready, 1'b1);
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00; lsu_bready = 1'b0;
    #1;
    chk("idle_bready", m_bready, 1'b0);
    chk("bvalid_once", lsu_bvalid, 1'b0);
    chk("w_beats", wbeats, v.exp_wbeats);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    case (v.kind)
      0: begin ifu_arvalid = 1'b1; ifu_araddr = v.addr; end
      1: begin lsu_arvalid = 1'b1; lsu_araddr = v.addr; lsu_arsize = v.size; end
      default: begin
        lsu_awvalid = 1'b1; lsu_awaddr = v.addr; lsu_awsize = v.size;
        lsu_wdata = v.data; lsu_wstrb = v.strb;
      end
    endcase
    grant_wait(cyc);
    chk("grant_latency", cyc, 1);
    if (v.kind == 2) serve_write(v);
    else serve_read(v.kind == 1, v.addr, v.data, v.resp, v.exp_size, v.exp_data, v.exp_resp);
  endtask

  initial begin
    int cyc;
    bit order[4];
    bit last_winner;
    vec_t v;

    //            kind addr          size  data          strb  resp aw w  exp_size exp_data      exp_resp wbeats
    vecs[0] = '{0, 32'h3000_0000, 3'd0, 32'h0010_0073, 4'h0, 2'd0, 0, 0, 3'b010, 32'h0010_0073, 2'd0, 0};
    vecs[1] = '{1, 32'h8000_0010, 3'd0, 32'h0000_00a5, 4'h0, 2'd2, 0, 0, 3'b000, 32'h0000_00a5, 2'd2, 0};
    vecs[2] = '{2, 32'h0f00_0004, 3'd2, 32'hdead_beef, 4'hf, 2'd0, 0, 2, 3'b010, 32'hdead_beef, 2'd0, 1};
    vecs[3] = '{2, 32'h0f00_0008, 3'd1, 32'h1234_5678, 4'h3, 2'd3, 2, 0, 3'b001, 32'h1234_5678, 2'd3, 1};
    vecs[4] = '{2, 32'h0f00_000c, 3'd0, 32'h0000_0055, 4'h1, 2'd0, 1, 1, 3'b000, 32'h0000_0055, 2'd0, 1};
    vecs[5] = '{0, 32'h3000_0004, 3'd0, 32'hffff_ffff, 4'h0, 2'd1, 0, 0, 3'b010, 32'hffff_ffff, 2'd1, 0};

`ifdef ARB_ROUND_ROBIN_EN
    order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    rst = 1'b1;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 1'b0;
    lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_awsize = '0;
    lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'b0);
      chk("rst_ifu_arready", ifu_arready, 1'b0);
      chk("rst_araddr", m_araddr, 32'h0);
    end
    rst = 1'b0;
    ifu_arvalid = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // IFU and LSU contend; the round winner re-requests at once so every arbitration is contended
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0200; lsu_arsize = 3'd2;
    for (int r = 0; r < 4; r++) begin
      grant_wait(cyc);
      chk("contend_latency", cyc, 1);
      chk("contend_winner", m_araddr, order[r] ? 32'h8000_0200 : 32'h3000_0100);
      if (order[r]) serve_read(1'b1, 32'h8000_0200, 32'h0000_1000 + r, 2'd0, 3'd2, 32'h0000_1000 + r, 2'd0);
      else          serve_read(1'b0, 32'h3000_0100, 32'h0000_2000 + r, 2'd0, 3'b010, 32'h0000_2000 + r, 2'd0);
      if (r < 3) begin
        if (order[r]) lsu_arvalid = 1'b1; else ifu_arvalid = 1'b1;
      end
    end
    last_winner = order[3];
    grant_wait(cyc);
    chk("loser_latency", cyc, 1);
    if (last_winner) serve_read(1'b0, 32'h3000_0100, 32'h0000_3000, 2'd0, 3'b010, 32'h0000_3000, 2'd0);
    else             serve_read(1'b1, 32'h8000_0200, 32'h0000_3000, 2'd0, 3'd2, 32'h0000_3000, 2'd0);

    // reset during LSU_WR after the AW handshake
    @(negedge clk);
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h0f00_0010; lsu_awsize = 3'd2;
    lsu_wdata = 32'hcafe_f00d; lsu_wstrb = 4'hf;
    grant_wait(cyc);
    m_awready = 1'b1;
    #1;
    chk("rstwr_awready", lsu_awready, 1'b1);
    @(negedge clk);
    lsu_awvalid = 1'b0; m_awready = 1'b0; lsu_wvalid = 1'b1;
    #1;
    chk("rstwr_wvalid_fwd", m_wvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b1; lsu_bready = 1'b1;
    #1;
    chk("rstwr_wvalid", m_wvalid, 1'b0);
    chk("rstwr_bready", m_bready, 1'b0);
    chk("rstwr_bvalid", lsu_bvalid, 1'b0);
    rst = 1'b0; lsu_wvalid = 1'b0; m_bvalid = 1'b0; lsu_bready = 1'b0;

    v = vecs[0];
    v.addr = 32'h3000_0008; v.data = 32'h0000_0013; v.exp_data = 32'h0000_0013;
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
